// File: rtl/platform_if.sv
// Bus between the platform manager, the character block (ball position in)
// and the colour mapper (platform read port out).
interface platform_if #(
    parameter int unsigned NUM_PLAT = 8
);
    localparam int unsigned IDX_W = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;

    logic [9:0]       BallX;
    logic [9:0]       BallY;
    logic [9:0]       BallS;
    logic [IDX_W-1:0] PlatIdx;
    logic [9:0]       PlatX;
    logic [9:0]       PlatY;
    logic             land;
    logic [9:0]       land_y;
    logic [9:0]       scroll_amt;
    logic             frame_done;
    logic [15:0]      score;
    logic             overrun;

    modport master (
        output BallX, BallY, BallS, PlatIdx,
        input  PlatX, PlatY, land, land_y, scroll_amt, frame_done, score, overrun
    );

    modport slave (
        input  BallX, BallY, BallS, PlatIdx,
        output PlatX, PlatY, land, land_y, scroll_amt, frame_done, score, overrun
    );
endinterface

// File: rtl/platform_manager.sv
// Per-frame platform game logic: landing detection, field scroll with
// pseudo-random respawn, and saturating score.
module platform_manager #(
    parameter int unsigned NUM_PLAT    = 8,
    parameter int unsigned PLAT_W      = 40,
    parameter int unsigned PLAT_H      = 4,
    parameter int unsigned SCROLL_LINE = 160,
    parameter int unsigned Y_MAX       = 479,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic     Clk,
    input  logic     Reset,
    input  logic     frame_clk,
    input  logic     run,
    platform_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLAT - 1);
    localparam logic [10:0] PH_11     = 11'(PLAT_H);
    localparam logic [10:0] PW_M1_11  = 11'(PLAT_W - 1);
    localparam logic [10:0] YMAX_11   = 11'(Y_MAX);
    localparam logic [10:0] YWRAP_11  = 11'(Y_MAX + 1);
    localparam logic [9:0]  SCROLL_10 = 10'(SCROLL_LINE);

    typedef enum logic [1:0] {IDLE, SCAN, SCROLL, DONE} state_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic             fc_q;
    logic [9:0]       sx, sx_nx, sy, sy_nx, ss, ss_nx;
    logic             falling, falling_nx;
    logic [9:0]       prev_y, prev_y_nx;
    logic [15:0]      lfsr;
    logic [9:0]       plat_x [NUM_PLAT];
    logic [9:0]       plat_y [NUM_PLAT];
    logic [9:0]       plat_x_nx [NUM_PLAT];
    logic [9:0]       plat_y_nx [NUM_PLAT];
    logic             hit_any, hit_any_nx;
    logic [9:0]       hit_y, hit_y_nx;
    logic             land_q, land_nx;
    logic [9:0]       land_y_q, land_y_nx;
    logic [9:0]       scroll_amt_q, scroll_amt_nx;
    logic             frame_done_q, frame_done_nx;
    logic [15:0]      score_q, score_nx;
    logic             overrun_q, overrun_nx;

    logic             frame_edge;
    logic [9:0]       delta_c;
    logic [10:0]      bot_c, right_c, px_c, py_c, ny_c;
    logic             hit_c;
    logic [16:0]      score_sum_c;
    logic             lfsr_fb;

    assign frame_edge  = frame_clk & ~fc_q;
    assign delta_c     = (sy < SCROLL_10) ? (SCROLL_10 - sy) : 10'd0;
    assign bot_c       = 11'(sy) + 11'(ss);
    assign right_c     = 11'(sx) + 11'(ss);
    assign px_c        = 11'(plat_x[idx]);
    assign py_c        = 11'(plat_y[idx]);
    assign ny_c        = py_c + 11'(delta_c);
    assign hit_c       = falling && (bot_c >= py_c) && (bot_c < py_c + PH_11)
                         && (right_c >= px_c) && (11'(sx) <= px_c + PW_M1_11);
    assign score_sum_c = {1'b0, score_q} + 17'(delta_c);
    assign lfsr_fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Next-state and next-register values; pulses are registered on entry to DONE
    always_comb begin
        state_nx      = state;
        idx_nx        = idx;
        sx_nx         = sx;
        sy_nx         = sy;
        ss_nx         = ss;
        falling_nx    = falling;
        prev_y_nx     = prev_y;
        plat_x_nx     = plat_x;
        plat_y_nx     = plat_y;
        hit_any_nx    = hit_any;
        hit_y_nx      = hit_y;
        land_nx       = 1'b0;
        frame_done_nx = 1'b0;
        land_y_nx     = land_y_q;
        scroll_amt_nx = scroll_amt_q;
        score_nx      = score_q;
        overrun_nx    = overrun_q | (frame_edge && (state != IDLE));

        case (state)
            IDLE: begin
                if (frame_edge && run) begin
                    sx_nx      = bus.BallX;
                    sy_nx      = bus.BallY;
                    ss_nx      = bus.BallS;
                    falling_nx = (bus.BallY > prev_y);
                    prev_y_nx  = bus.BallY;
                    idx_nx     = '0;
                    hit_any_nx = 1'b0;
                    state_nx   = SCAN;
                end
            end
            SCAN: begin
                if (hit_c && !hit_any) begin
                    hit_any_nx = 1'b1;
                    hit_y_nx   = plat_y[idx];
                end
                if (idx == LAST_IDX) begin
                    idx_nx   = '0;
                    state_nx = (delta_c != 10'd0) ? SCROLL : DONE;
                end else begin
                    idx_nx = idx + IDX_W'(1);
                end
            end
            SCROLL: begin
                if (ny_c > YMAX_11) begin
                    plat_y_nx[idx] = 10'(ny_c - YWRAP_11);
                    plat_x_nx[idx] = {1'b0, lfsr[8:0]} + 10'd32;
                end else begin
                    plat_y_nx[idx] = ny_c[9:0];
                end
                if (idx == LAST_IDX) begin
                    idx_nx   = '0;
                    state_nx = DONE;
                end else begin
                    idx_nx = idx + IDX_W'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        if (state_nx == DONE) begin
            frame_done_nx = 1'b1;
            land_nx       = hit_any_nx;
            if (hit_any_nx) land_y_nx = hit_y_nx;
            scroll_amt_nx = delta_c;
            score_nx      = score_sum_c[16] ? 16'hFFFF : score_sum_c[15:0];
        end
    end

    always_ff @(posedge Clk) begin
        fc_q <= frame_clk;
        if (Reset) begin
            state        <= IDLE;
            idx          <= '0;
            sx           <= '0;
            sy           <= '0;
            ss           <= '0;
            falling      <= 1'b0;
            prev_y       <= '0;
            lfsr         <= LFSR_SEED;
            hit_any      <= 1'b0;
            hit_y        <= '0;
            land_q       <= 1'b0;
            land_y_q     <= '0;
            scroll_amt_q <= '0;
            frame_done_q <= 1'b0;
            score_q      <= '0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < NUM_PLAT; i++) begin
                plat_x[i] <= 10'(64 * i + 32);
                plat_y[i] <= 10'(Y_MAX - 60 * i);
            end
        end else begin
            state        <= state_nx;
            idx          <= idx_nx;
            sx           <= sx_nx;
            sy           <= sy_nx;
            ss           <= ss_nx;
            falling      <= falling_nx;
            prev_y       <= prev_y_nx;
            lfsr         <= {lfsr[14:0], lfsr_fb};
            hit_any      <= hit_any_nx;
            hit_y        <= hit_y_nx;
            land_q       <= land_nx;
            land_y_q     <= land_y_nx;
            scroll_amt_q <= scroll_amt_nx;
            frame_done_q <= frame_done_nx;
            score_q      <= score_nx;
            overrun_q    <= overrun_nx;
            plat_x       <= plat_x_nx;
            plat_y       <= plat_y_nx;
        end
    end

    assign bus.PlatX      = plat_x[bus.PlatIdx];
    assign bus.PlatY      = plat_y[bus.PlatIdx];
    assign bus.land       = land_q;
    assign bus.land_y     = land_y_q;
    assign bus.scroll_amt = scroll_amt_q;
    assign bus.frame_done = frame_done_q;
    assign bus.score      = score_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_platform_manager.sv
// Directed bench for platform_manager with hand-computed expectations.
module tb_platform_manager;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic frame_clk = 1'b0;
    logic run = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    platform_if #(.NUM_PLAT(8)) bus ();

    platform_manager dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .run       (run),
        .bus       (bus.slave)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic read_plat(input int i, output logic [9:0] x, output logic [9:0] y);
        bus.PlatIdx = 3'(i);
        #1;
        x = bus.PlatX;
        y = bus.PlatY;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Launch one frame; cycle k is sampled on the negedge before posedge k.
    task automatic run_frame(input logic [9:0] x, input logic [9:0] y, input logic [9:0] s,
                             input bit dbl, input int rst_at,
                             output int done_at, output int land_at);
        @(negedge Clk);
        bus.BallX = x;
        bus.BallY = y;
        bus.BallS = s;
        frame_clk = 1'b1;
        @(posedge Clk);
        done_at = -1;
        land_at = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clk);
            if (k == 2) frame_clk = 1'b0;
            if (dbl && k == 4) frame_clk = 1'b1;
            if (dbl && k == 6) frame_clk = 1'b0;
            if (k == rst_at) Reset = 1'b1;
            if (k == rst_at + 1) Reset = 1'b0;
            if (bus.land && land_at < 0) land_at = k;
            if (bus.frame_done && done_at < 0) done_at = k;
            if (done_at >= 0) break;
        end
        if (done_at >= 0) begin
            @(negedge Clk);
            check("pulse_width", {30'd0, bus.frame_done, bus.land}, 32'd0);
        end
    endtask

    logic [9:0] px, py;
    int done_at, land_at;

    initial begin
        bus.BallX = '0;
        bus.BallY = '0;
        bus.BallS = '0;
        bus.PlatIdx = '0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        // Initial layout and idle outputs
        for (int i = 0; i < 8; i++) begin
            read_plat(i, px, py);
            check($sformatf("init_x%0d", i), 32'(px), 32'(64 * i + 32));
            check($sformatf("init_y%0d", i), 32'(py), 32'(479 - 60 * i));
        end
        check("init_pulses", {29'd0, bus.land, bus.frame_done, bus.overrun}, 32'd0);
        check("init_score", 32'(bus.score), 32'd0);

        // Frame 1: no hit, no scroll
        run_frame(10'd100, 10'd200, 10'd4, 1'b0, -1, done_at, land_at);
        check("f1_done_at", 32'(done_at), 32'd9);
        check("f1_land", 32'(land_at), 32'hFFFFFFFF);

        // Frame 2: falling onto platform 4 (Y=239, X=288)
        run_frame(10'd290, 10'd235, 10'd4, 1'b0, -1, done_at, land_at);
        check("f2_done_at", 32'(done_at), 32'd9);
        check("f2_land_at", 32'(land_at), 32'd9);
        check("f2_land_y", 32'(bus.land_y), 32'd239);
        check("f2_scroll", 32'(bus.scroll_amt), 32'd0);

        // Frame 3: same footprint but rising
        run_frame(10'd290, 10'd230, 10'd9, 1'b0, -1, done_at, land_at);
        check("f3_done_at", 32'(done_at), 32'd9);
        check("f3_land", 32'(land_at), 32'hFFFFFFFF);
        check("f3_land_y_held", 32'(bus.land_y), 32'd239);

        // Frame 4: above scroll line, delta 60
        run_frame(10'd0, 10'd100, 10'd4, 1'b0, -1, done_at, land_at);
        check("f4_done_at", 32'(done_at), 32'd17);
        check("f4_scroll", 32'(bus.scroll_amt), 32'd60);
        check("f4_score", 32'(bus.score), 32'd60);
        read_plat(0, px, py);
        check("f4_p0_y", 32'(py), 32'd59);
        check("f4_p0_x_range", 32'(px >= 10'd32 && px <= 10'd543), 32'd1);
        read_plat(1, px, py);
        check("f4_p1_y", 32'(py), 32'd479);
        check("f4_p1_x", 32'(px), 32'd96);
        read_plat(6, px, py);
        check("f4_p6_y", 32'(py), 32'd179);
        read_plat(7, px, py);
        check("f4_p7_y", 32'(py), 32'd119);

        // Frame 5: last window row, ball left edge on platform right edge
        run_frame(10'd455, 10'd172, 10'd10, 1'b0, -1, done_at, land_at);
        check("f5_land_at", 32'(land_at), 32'd9);
        check("f5_land_y", 32'(bus.land_y), 32'd179);

        // Frame 6: one row below the window misses
        run_frame(10'd352, 10'd239, 10'd4, 1'b0, -1, done_at, land_at);
        check("f6_done_at", 32'(done_at), 32'd9);
        check("f6_land", 32'(land_at), 32'hFFFFFFFF);

        // Second frame edge while busy
        check("ovr_before", 32'(bus.overrun), 32'd0);
        run_frame(10'd0, 10'd300, 10'd4, 1'b1, -1, done_at, land_at);
        check("ovr_done_at", 32'(done_at), 32'd9);
        check("ovr_set", 32'(bus.overrun), 32'd1);
        run_frame(10'd0, 10'd310, 10'd4, 1'b0, -1, done_at, land_at);
        check("ovr_next_done", 32'(done_at), 32'd9);
        check("ovr_sticky", 32'(bus.overrun), 32'd1);

        // run low: edges ignored
        run = 1'b0;
        @(negedge Clk);
        frame_clk = 1'b1;
        done_at = -1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge Clk);
            if (k == 3) frame_clk = 1'b0;
            if (bus.frame_done && done_at < 0) done_at = k;
        end
        check("run_low_ignored", 32'(done_at), 32'hFFFFFFFF);
        run = 1'b1;

        do_reset();
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        check("rst_score", 32'(bus.score), 32'd0);
        check("rst_land_y", 32'(bus.land_y), 32'd0);

        // Saturation: 160 per frame, 409 frames = 0xFFA0
        for (int f = 0; f < 409; f++)
            run_frame(10'd0, 10'd0, 10'd0, 1'b0, -1, done_at, land_at);
        check("sat_pre", 32'(bus.score), 32'h0000FFA0);
        run_frame(10'd0, 10'd0, 10'd0, 1'b0, -1, done_at, land_at);
        check("sat_done_at", 32'(done_at), 32'd17);
        check("sat_scroll", 32'(bus.scroll_amt), 32'd160);
        check("sat_score", 32'(bus.score), 32'h0000FFFF);
        run_frame(10'd0, 10'd0, 10'd0, 1'b0, -1, done_at, land_at);
        check("sat_hold", 32'(bus.score), 32'h0000FFFF);

        // Reset during a scroll burst
        do_reset();
        run_frame(10'd0, 10'd100, 10'd4, 1'b0, 12, done_at, land_at);
        check("midrst_no_done", 32'(done_at), 32'hFFFFFFFF);
        check("midrst_score", 32'(bus.score), 32'd0);
        for (int i = 0; i < 8; i += 3) begin
            read_plat(i, px, py);
            check($sformatf("midrst_x%0d", i), 32'(px), 32'(64 * i + 32));
            check($sformatf("midrst_y%0d", i), 32'(py), 32'(479 - 60 * i));
        end
        run_frame(10'd0, 10'd100, 10'd4, 1'b0, -1, done_at, land_at);
        check("post_rst_done_at", 32'(done_at), 32'd17);
        check("post_rst_score", 32'(bus.score), 32'd60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
